// File: rtl/cam_power_seq_pkg.sv
// ---------------------------------------------------------------------------
// cam_power_seq_pkg
// Shared definitions for the OV7670 power/initialisation sequencer:
//   - state encodings (also presented on o_state for debug)
//   - state and millisecond-count widths
//   - cycles-per-millisecond derivation from the clock frequency
// ---------------------------------------------------------------------------
package cam_power_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned MS_W    = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_WAKE   = 3'd2,
    ST_CONFIG = 3'd3,
    ST_SETTLE = 3'd4,
    ST_READY  = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // Clock cycles per millisecond; never below one so the prescaler is valid.
  function automatic int unsigned cyc_ms(input int unsigned clk_freq);
    return ((clk_freq / 1000) > 0) ? (clk_freq / 1000) : 1;
  endfunction

endpackage

// File: rtl/cam_power_seq_timer.sv
// ---------------------------------------------------------------------------
// cam_ms_timer
// Millisecond duration timer: a CYC_MS prescaler producing a ms tick and a
// down-counter of whole milliseconds. Both reload on i_load so that a state
// lasting i_ms milliseconds expires cycle-exactly.
// Ports:
//   i_clk     system clock
//   i_rstn    synchronous active-low reset
//   i_load    high in the first cycle of a timed interval (state entry)
//   i_ms      interval length in ms (>= 1), sampled while i_load is high
//   o_expire  high in the last cycle of the interval
// ---------------------------------------------------------------------------
module cam_ms_timer #(
  parameter int unsigned CYC_MS = 75000,
  parameter int unsigned MS_W   = 16
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_load,
  input  logic [MS_W-1:0] i_ms,
  output logic            o_expire
);

  localparam int unsigned     PRE_W    = (CYC_MS > 1) ? $clog2(CYC_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYC_MS - 1);

  logic [PRE_W-1:0] r_pre;
  logic [MS_W-1:0]  r_ms;
  logic             w_load_exp;
  logic             w_run_exp;

  // The load cycle itself is the first elapsed cycle of the interval, so the
  // prescaler restarts at 1 (or, with a 1-cycle ms, one whole ms is consumed).
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (i_load) begin
      if (CYC_MS == 1) begin
        r_pre <= '0;
        r_ms  <= (i_ms == '0) ? '0 : (i_ms - 1'b1);
      end else begin
        r_pre <= PRE_W'(1);
        r_ms  <= i_ms;
      end
    end else if (r_ms != '0) begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        r_ms  <= r_ms - 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // A one-cycle interval can only expire in its own load cycle.
  always_comb begin
    w_load_exp = (CYC_MS == 1) && (i_ms <= MS_W'(1));
    w_run_exp  = (r_ms == MS_W'(1)) && (r_pre == PRE_LAST);
    o_expire   = i_load ? w_load_exp : w_run_exp;
  end

endmodule

// File: rtl/cam_power_seq.sv
// ---------------------------------------------------------------------------
// cam_power_seq
// Power-up / re-initialisation sequencer for the OV7670: drives PWDN and
// RESET with the datasheet wake-up delays, triggers the SCCB register load,
// discards a number of settling frames and then enables capture.
// Ports:
//   i_clk         system clock
//   i_rstn        synchronous active-low reset
//   i_start       start/restart level (honoured in IDLE, READY, ERROR)
//   i_cfg_done    done level from the configuration block
//   i_vsync       camera VSYNC, synchronised to i_clk
//   o_cam_pwdn    sensor PWDN, active-high
//   o_cam_rstn    sensor RESET, active-low
//   o_cfg_start   one-cycle start pulse to the configuration block
//   o_capture_en  capture datapath enable
//   o_ready       sequence complete
//   o_error       config or frame timeout occurred
//   o_state       current state encoding (debug)
// ---------------------------------------------------------------------------
module cam_power_seq
  import cam_power_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ         = 75000000,
  parameter int unsigned RST_LOW_MS       = 1,
  parameter int unsigned WAKE_MS          = 1,
  parameter int unsigned CFG_TIMEOUT_MS   = 500,
  parameter int unsigned SETTLE_FRAMES    = 10,
  parameter int unsigned FRAME_TIMEOUT_MS = 100
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic               i_cfg_done,
  input  logic               i_vsync,
  output logic               o_cam_pwdn,
  output logic               o_cam_rstn,
  output logic               o_cfg_start,
  output logic               o_capture_en,
  output logic               o_ready,
  output logic               o_error,
  output logic [STATE_W-1:0] o_state
);

  localparam int unsigned CYC_MS = cyc_ms(CLK_FREQ);
  localparam int unsigned FRM_W  = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;

  state_t            r_state;
  state_t            w_nxt;
  logic              r_cam_pwdn;
  logic              r_cam_rstn;
  logic              r_cfg_start;
  logic              r_capture_en;
  logic              r_ready;
  logic              r_error;
  logic              r_tmr_load;
  logic              r_done_prev;
  logic              r_vs_prev;
  logic [FRM_W-1:0]  r_frames;

  logic              w_done_rise;
  logic              w_vs_rise;
  logic              w_last_frame;
  logic              w_tmr_load;
  logic              w_expire;
  logic [MS_W-1:0]   w_tmr_ms;

  // Edge detectors run in every state so a level that was already high
  // before CONFIG/SETTLE never counts as an event.
  always_comb begin
    w_done_rise  = i_cfg_done & ~r_done_prev;
    w_vs_rise    = i_vsync & ~r_vs_prev;
    w_last_frame = ((32'(r_frames) + 32'd1) == 32'(SETTLE_FRAMES));
  end

  // The frame timeout restarts on every VSYNC edge seen during SETTLE.
  always_comb begin
    w_tmr_load = r_tmr_load | ((r_state == ST_SETTLE) & w_vs_rise);
    case (r_state)
      ST_RESET:  w_tmr_ms = MS_W'(RST_LOW_MS);
      ST_WAKE:   w_tmr_ms = MS_W'(WAKE_MS);
      ST_CONFIG: w_tmr_ms = MS_W'(CFG_TIMEOUT_MS);
      ST_SETTLE: w_tmr_ms = MS_W'(FRAME_TIMEOUT_MS);
      default:   w_tmr_ms = MS_W'(1);
    endcase
  end

  cam_ms_timer #(
    .CYC_MS (CYC_MS),
    .MS_W   (MS_W)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_load   (w_tmr_load),
    .i_ms     (w_tmr_ms),
    .o_expire (w_expire)
  );

  // Next state; event edges take priority over a coincident timeout.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_nxt = ST_RESET;
      ST_RESET:  if (w_expire) w_nxt = ST_WAKE;
      ST_WAKE:   if (w_expire) w_nxt = ST_CONFIG;
      ST_CONFIG: begin
        if (w_done_rise)   w_nxt = (SETTLE_FRAMES == 0) ? ST_READY : ST_SETTLE;
        else if (w_expire) w_nxt = ST_ERROR;
      end
      ST_SETTLE: begin
        if (w_vs_rise) begin
          if (w_last_frame) w_nxt = ST_READY;
        end else if (w_expire) begin
          w_nxt = ST_ERROR;
        end
      end
      ST_READY:  if (i_start) w_nxt = ST_RESET;
      ST_ERROR:  if (i_start) w_nxt = ST_RESET;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // State register with outputs decoded from the next state, so outputs
  // change on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= ST_IDLE;
      r_cam_pwdn   <= 1'b1;
      r_cam_rstn   <= 1'b0;
      r_cfg_start  <= 1'b0;
      r_capture_en <= 1'b0;
      r_ready      <= 1'b0;
      r_error      <= 1'b0;
      r_tmr_load   <= 1'b0;
      r_done_prev  <= 1'b0;
      r_vs_prev    <= 1'b0;
      r_frames     <= '0;
    end else begin
      r_done_prev  <= i_cfg_done;
      r_vs_prev    <= i_vsync;
      r_state      <= w_nxt;
      r_tmr_load   <= (w_nxt != r_state);
      r_cfg_start  <= (w_nxt == ST_CONFIG) && (r_state != ST_CONFIG);
      r_cam_pwdn   <= (w_nxt == ST_IDLE) || (w_nxt == ST_ERROR);
      r_cam_rstn   <= !((w_nxt == ST_IDLE) || (w_nxt == ST_RESET) || (w_nxt == ST_ERROR));
      r_capture_en <= (w_nxt == ST_READY);
      r_ready      <= (w_nxt == ST_READY);
      r_error      <= (w_nxt == ST_ERROR);
      if ((w_nxt == ST_SETTLE) && (r_state != ST_SETTLE)) begin
        r_frames <= '0;
      end else if ((r_state == ST_SETTLE) && w_vs_rise) begin
        r_frames <= r_frames + 1'b1;
      end
    end
  end

  assign o_cam_pwdn   = r_cam_pwdn;
  assign o_cam_rstn   = r_cam_rstn;
  assign o_cfg_start  = r_cfg_start;
  assign o_capture_en = r_capture_en;
  assign o_ready      = r_ready;
  assign o_error      = r_error;
  assign o_state      = r_state;

endmodule

// File: tb/tb_cam_power_seq.sv
// ---------------------------------------------------------------------------
// tb_cam_power_seq
// Directed bench for cam_power_seq at 10 cycles/ms. A deadline-based
// behavioural model predicts every output each cycle; literal checks pin
// the key timing points of each scenario.
// ---------------------------------------------------------------------------
module tb_cam_power_seq;

  localparam int CM = 10;   // cycles per ms at CLK_FREQ=10000
  localparam int RL = 1;
  localparam int WK = 2;
  localparam int CT = 5;
  localparam int SF = 2;
  localparam int FT = 3;

  logic       clk = 1'b0;
  logic       rstn, start, cfg_done, vsync;
  logic       cam_pwdn, cam_rstn, cfg_start, capture_en, ready, error;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  cam_power_seq #(
    .CLK_FREQ         (10000),
    .RST_LOW_MS       (RL),
    .WAKE_MS          (WK),
    .CFG_TIMEOUT_MS   (CT),
    .SETTLE_FRAMES    (SF),
    .FRAME_TIMEOUT_MS (FT)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .i_cfg_done   (cfg_done),
    .i_vsync      (vsync),
    .o_cam_pwdn   (cam_pwdn),
    .o_cam_rstn   (cam_rstn),
    .o_cfg_start  (cfg_start),
    .o_capture_en (capture_en),
    .o_ready      (ready),
    .o_error      (error),
    .o_state      (state)
  );

  initial forever #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Phase plus absolute exit-cycle deadline. Cycle c is the interval that
  // follows clock edge c; a phase of D cycles entered at edge E leaves at E+D.
  int m_state = 0;
  int m_dl    = 0;
  int m_fr    = 0;
  bit m_dp    = 0;
  bit m_vp    = 0;
  bit m_cs    = 0;

  function automatic int dur(input int s);
    case (s)
      1:       return RL * CM;
      2:       return WK * CM;
      3:       return CT * CM;
      4:       return FT * CM;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int ns;
    bit dr, vr;
    cyc = cyc + 1;
    if (!rstn) begin
      m_state = 0; m_fr = 0; m_dp = 0; m_vp = 0; m_cs = 0;
    end else begin
      dr = cfg_done && !m_dp;
      vr = vsync && !m_vp;
      ns = m_state;
      case (m_state)
        0, 5, 6: if (start) ns = 1;
        1, 2:    if (cyc == m_dl) ns = m_state + 1;
        3: begin
          if (dr) ns = (SF == 0) ? 5 : 4;
          else if (cyc == m_dl) ns = 6;
        end
        4: begin
          if (vr) begin
            m_fr = m_fr + 1;
            if (m_fr >= SF) ns = 5;
            else m_dl = cyc - 1 + FT * CM;   // edge arrived during previous cycle
          end else if (cyc == m_dl) ns = 6;
        end
        default: ns = 0;
      endcase
      m_cs = (ns == 3) && (m_state != 3);
      if (ns != m_state) begin
        m_dl = cyc + dur(ns);
        if (ns == 4) m_fr = 0;
      end
      m_state = ns;
      m_dp = cfg_done;
      m_vp = vsync;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic [8:0] exp_v, act_v;
    @(negedge clk);
    if (chk_en) begin
      exp_v = {3'(m_state),
               (m_state == 0) || (m_state == 6),
               !((m_state == 0) || (m_state == 1) || (m_state == 6)),
               m_cs, m_state == 5, m_state == 5, m_state == 6};
      act_v = {state, cam_pwdn, cam_rstn, cfg_start, capture_en, ready, error};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model_cmp cycle %0d: got {st,pwdn,rstn,cfg,cap,rdy,err}=%b expected %b",
                 cyc, act_v, exp_v);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Advance to the negedge inside cycle c.
  task automatic goto(input int c);
    int guard = 0;
    if (c < cyc) begin
      checks++;
      failures++;
      $display("FAIL goto: target cycle %0d already passed (now %0d)", c, cyc);
    end
    while (cyc < c && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int b, r, e, f, g;
    rstn = 1'b0; start = 1'b0; cfg_done = 1'b0; vsync = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_pwdn", cam_pwdn, 1);
    chk("rst_rstn", cam_rstn, 0);
    chk("rst_others", {cfg_start, capture_en, ready, error}, 0);
    chk_en = 1;
    rstn = 1'b1;

    // Nominal sequence
    b = cyc + 2;
    goto(b);      start = 1'b1;
    goto(b + 1);  start = 1'b0;
    chk("nom_state_reset", state, 1);
    chk("nom_pwdn_fall", cam_pwdn, 0);
    goto(b + 10); chk("nom_rstn_low", cam_rstn, 0);
    goto(b + 11); chk("nom_rstn_rise", cam_rstn, 1);
    goto(b + 30); chk("nom_cfg_pre", cfg_start, 0);
    goto(b + 31); chk("nom_cfg_pulse", cfg_start, 1);
    goto(b + 32); chk("nom_cfg_post", cfg_start, 0);
    goto(b + 38); cfg_done = 1'b1;
    goto(b + 39); chk("nom_settle", state, 4);
    goto(b + 45); vsync = 1'b1;
    goto(b + 47); vsync = 1'b0;
    goto(b + 52); vsync = 1'b1;
    chk("nom_ready_pre", ready, 0);
    goto(b + 53);
    chk("nom_ready", ready, 1);
    chk("nom_cap", capture_en, 1);
    goto(b + 55); vsync = 1'b0;

    // Re-init from READY; start held (ignored in RESET); stale done stays high
    r = b + 60;
    goto(r);      start = 1'b1;
    goto(r + 1);
    chk("reinit_state", state, 1);
    chk("reinit_cap", capture_en, 0);
    goto(r + 5);  start = 1'b0;
    goto(r + 31); chk("reinit_cfg_pulse", cfg_start, 1);
    goto(r + 80); chk("stale_still_cfg", state, 3);
    goto(r + 81);
    chk("stale_err_state", state, 6);
    chk("stale_err", error, 1);
    chk("stale_pwdn", cam_pwdn, 1);
    chk("stale_rstn", cam_rstn, 0);

    // Config timeout with done low, restarting from ERROR
    e = r + 85;
    goto(e);      start = 1'b1; cfg_done = 1'b0;
    goto(e + 1);  start = 1'b0;
    chk("err_restart", state, 1);
    chk("err_clear", error, 0);
    goto(e + 80); chk("cto_before", state, 3);
    goto(e + 81); chk("cto_error", state, 6);

    // Frame timeout: one VSYNC edge then silence
    f = e + 85;
    goto(f);      start = 1'b1;
    goto(f + 1);  start = 1'b0;
    goto(f + 34); cfg_done = 1'b1;
    goto(f + 35); chk("fto_settle", state, 4);
    goto(f + 40); vsync = 1'b1;
    goto(f + 41); vsync = 1'b0;
    goto(f + 69); chk("fto_before", state, 4);
    goto(f + 70); chk("fto_error", state, 6);

    // Done edge coincident with config timeout, then reset mid-SETTLE
    g = f + 75;
    goto(g);      start = 1'b1; cfg_done = 1'b0;
    goto(g + 1);  start = 1'b0;
    goto(g + 80); cfg_done = 1'b1;
    goto(g + 81); chk("edge_beats_timeout", state, 4);
    goto(g + 83); vsync = 1'b1;
    goto(g + 84); vsync = 1'b0;
    goto(g + 87); rstn = 1'b0;
    goto(g + 88); rstn = 1'b1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_pwdn", cam_pwdn, 1);
    chk("mid_rst_rstn", cam_rstn, 0);
    chk("mid_rst_others", {cfg_start, capture_en, ready, error}, 0);
    goto(g + 90);  start = 1'b1;
    goto(g + 91);  start = 1'b0;
    chk("post_rst_start", state, 1);
    goto(g + 115); cfg_done = 1'b0;
    goto(g + 121); chk("post_rst_cfg", cfg_start, 1);
    goto(g + 125); cfg_done = 1'b1;
    goto(g + 128); vsync = 1'b1;
    goto(g + 130); vsync = 1'b0;
    goto(g + 133); vsync = 1'b1;
    chk("post_rst_ready_pre", ready, 0);
    goto(g + 134); chk("post_rst_ready", ready, 1);
    goto(g + 136); vsync = 1'b0; cfg_done = 1'b0;
    goto(g + 140);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
